uart_tx_queue: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_tx_queue.sv | 115 +++++++++++
 tb/tb_uart_tx_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths/depths and the TX queue FSM state type.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_TXQ_DEPTH  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic circular FIFO with occupancy counter; storage is flopped and the head entry is
// presented directly so the consumer can capture it on the pop edge.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = UART_TXQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [DATA_WIDTH-1:0]   pop_data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full_q, empty_q;
  logic                  do_push, do_pop;

  // Full is judged on the registered flag, so a same-cycle pop never frees a slot early.
  assign do_push = push_i && !full_q && !flush_i;
  assign do_pop  = pop_i && !empty_q && !flush_i;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CntW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding UART_TX with a one-cycle enable and busy/done handshake.
// Define UART_TXQ_IRQ_EN to enable the low-watermark interrupt on irq_low_o.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = UART_TXQ_DEPTH,
  parameter int unsigned LOW_WATER  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic                   flush_i,
  output logic [DATA_WIDTH-1:0]  tx_data_o,
  output logic                   tx_en_o,
  input  logic                   tx_busy_i,
  input  logic                   tx_done_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   overflow_o,
  output logic                   irq_low_o
);

  txq_state_t            state_q;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_en_q;
  logic                  overflow_q;
  logic                  pop;

  // A flush cycle suppresses issue so the discarded head is never sent.
  assign pop        = (state_q == StIdle) && !empty_o && !tx_busy_i && !flush_i;
  assign wr_ready_o = !full_o;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wr_valid_i),
    .push_data_i (wr_data_i),
    .pop_i       (pop),
    .flush_i     (flush_i),
    .pop_data_o  (head_data),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_data_q <= head_data;
            tx_en_q   <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: state_q <= StWaitBusy;
        StWaitBusy: begin
          // Done before busy is a degenerate short frame; go straight back to idle.
          if (tx_done_i) begin
            state_q <= StIdle;
          end else if (tx_busy_i) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (tx_done_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      overflow_q <= 1'b0;
    end else if (wr_valid_i && full_o) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef UART_TXQ_IRQ_EN
  logic irq_low_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_low_q <= 1'b0;
    end else begin
      irq_low_q <= (32'(count_o) <= LOW_WATER);
    end
  end

  assign irq_low_o = irq_low_q;
`else
  // Low for every legal LOW_WATER (< DEPTH).
  assign irq_low_o = (LOW_WATER >= DEPTH);
`endif

  assign tx_data_o  = tx_data_q;
  assign tx_en_o    = tx_en_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a small behavioural transmitter.
module tb_uart_tx_queue;

  localparam int unsigned DW       = 8;
  localparam int unsigned Depth    = 16;
  localparam int unsigned LowWater = 4;
  localparam int unsigned CntW     = 5;
  localparam int          FrameLen = 12;
`ifdef UART_TXQ_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic            flush = 1'b0;
  logic [DW-1:0]   tx_data;
  logic            tx_en;
  logic            tx_busy;
  logic            tx_done = 1'b0;
  logic [CntW-1:0] count;
  logic            empty, full, overflow, irq_low;

  logic            hold_busy = 1'b0;
  logic            frame_busy = 1'b0;
  logic            prev_en = 1'b0;
  bit              done_armed = 1'b0;
  int              frame_cnt = 0;
  int              neg_idx = 0;
  int              done_idx = 0;
  logic [DW-1:0]   sent_q[$];
  int              n_checks = 0;
  int              n_errors = 0;

  assign tx_busy = hold_busy | frame_busy;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (Depth),
    .LOW_WATER  (LowWater)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data_i  (wr_data),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .flush_i    (flush),
    .tx_data_o  (tx_data),
    .tx_en_o    (tx_en),
    .tx_busy_i  (tx_busy),
    .tx_done_i  (tx_done),
    .count_o    (count),
    .empty_o    (empty),
    .full_o     (full),
    .overflow_o (overflow),
    .irq_low_o  (irq_low)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_byte(input logic [DW-1:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string p);
    chk({p, "_tx_en"},    32'(tx_en),    0);
    chk({p, "_tx_data"},  32'(tx_data),  0);
    chk({p, "_count"},    32'(count),    0);
    chk({p, "_empty"},    32'(empty),    1);
    chk({p, "_full"},     32'(full),     0);
    chk({p, "_wr_ready"}, 32'(wr_ready), 1);
    chk({p, "_overflow"}, 32'(overflow), 0);
    chk({p, "_irq_low"},  32'(irq_low),  0);
  endtask

  task automatic wait_drain(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      @(negedge clk);
      idle = (count == '0) && !frame_busy && !tx_en && !tx_done && !hold_busy;
    end
    chk({tag, "_drain"}, 32'(idle), 1);
    repeat (3) @(negedge clk);
  endtask

  // Transmitter model plus handshake monitors, evaluated away from the active edge.
  always @(negedge clk) begin
    neg_idx++;
    if (tx_en) begin
      chk("en_while_busy", 32'(tx_busy), 0);
      chk("en_pulse_width", 32'(prev_en), 0);
      if (done_armed) begin
        chk("done_to_en_gap", 32'(neg_idx - done_idx), 2);
        done_armed = 1'b0;
      end
    end
    prev_en = tx_en;
    if (rst) begin
      frame_busy = 1'b0;
      tx_done    = 1'b0;
      frame_cnt  = 0;
      done_armed = 1'b0;
    end else if (tx_en) begin
      sent_q.push_back(tx_data);
      frame_busy = 1'b1;
      frame_cnt  = FrameLen;
      tx_done    = 1'b0;
    end else if (frame_busy) begin
      if (frame_cnt == 1) begin
        frame_busy = 1'b0;
        tx_done    = 1'b1;
        if (count != '0) begin
          done_armed = 1'b1;
          done_idx   = neg_idx;
        end
      end else begin
        frame_cnt--;
      end
    end else begin
      tx_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;

    // Single byte: issue one edge after the write edge, one-cycle enable.
    write_byte(8'hA5);
    chk("t1_count_after_write", 32'(count), 1);
    chk("t1_empty_after_write", 32'(empty), 0);
    chk("t1_en_not_yet",        32'(tx_en), 0);
    @(negedge clk);
    chk("t1_en",        32'(tx_en),   1);
    chk("t1_data",      32'(tx_data), 32'hA5);
    chk("t1_count_pop", 32'(count),   0);
    chk("t1_empty_pop", 32'(empty),   1);
    @(negedge clk);
    chk("t1_en_low", 32'(tx_en), 0);
    repeat (4) @(negedge clk);
    chk("t1_data_held", 32'(tx_data), 32'hA5);
    wait_drain("t1");
    chk("t1_sent_n",    32'(sent_q.size()), 1);
    chk("t1_sent_byte", 32'(sent_q[0]),     32'hA5);

    // Burst of five back-to-back writes.
    base = sent_q.size();
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    chk("t2_count_peak", 32'(count), 4);
    wait_drain("t2");
    chk("t2_sent_n", 32'(sent_q.size()), 32'(base + 5));
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), 32'(sent_q[base + i]), 32'(i + 1));

    // Fill with transmitter held busy, then one refused write.
    hold_busy = 1'b1;
    base = sent_q.size();
    for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i));
    chk("t3_count_full", 32'(count),    16);
    chk("t3_full",       32'(full),     1);
    chk("t3_wr_ready",   32'(wr_ready), 0);
    chk("t3_ovf_clear",  32'(overflow), 0);
    write_byte(8'hEE);
    chk("t3_ovf_set",    32'(overflow), 1);
    chk("t3_count_held", 32'(count),    16);
    hold_busy = 1'b0;
    wait_drain("t3");
    chk("t3_sent_n",      32'(sent_q.size()), 32'(base + 16));
    for (int i = 0; i < 16; i++) chk($sformatf("t3_order%0d", i), 32'(sent_q[base + i]), 32'(8'h10 + i));
    chk("t3_ovf_sticky", 32'(overflow), 1);

    // Flush with six queued and one in flight; the in-flight byte still completes.
    base = sent_q.size();
    for (int i = 0; i < 7; i++) write_byte(8'(8'h30 + i));
    chk("t4_count_pre", 32'(count), 6);
    flush    = 1'b1;
    wr_data  = 8'h77;
    wr_valid = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    wr_valid = 1'b0;
    chk("t4_count",    32'(count),    0);
    chk("t4_empty",    32'(empty),    1);
    chk("t4_overflow", 32'(overflow), 0);
    wait_drain("t4");
    chk("t4_sent_n",    32'(sent_q.size()), 32'(base + 1));
    chk("t4_sent_byte", 32'(sent_q[base]),  32'h30);

    // A pop that would coincide with flush must not issue.
    hold_busy = 1'b1;
    write_byte(8'h21);
    write_byte(8'h22);
    base = sent_q.size();
    hold_busy = 1'b0;
    flush     = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_no_en",  32'(tx_en), 0);
    chk("t5_count",  32'(count), 0);
    repeat (3) @(negedge clk);
    chk("t5_sent_n", 32'(sent_q.size()), 32'(base));

    // Simultaneous write and pop at count 3.
    hold_busy = 1'b1;
    base = sent_q.size();
    for (int i = 0; i < 3; i++) write_byte(8'(8'h40 + i));
    chk("t6_count_pre", 32'(count), 3);
    hold_busy = 1'b0;
    write_byte(8'h43);
    chk("t6_count_same", 32'(count),   3);
    chk("t6_en",         32'(tx_en),   1);
    chk("t6_data",       32'(tx_data), 32'h40);
    wait_drain("t6");
    for (int i = 0; i < 4; i++) chk($sformatf("t6_order%0d", i), 32'(sent_q[base + i]), 32'(8'h40 + i));

    // Low-watermark interrupt lags count by one cycle.
    hold_busy = 1'b1;
    chk("t7_irq_empty", 32'(irq_low), 32'(IrqEn));
    for (int i = 0; i < 5; i++) begin
      write_byte(8'(8'h60 + i));
      chk($sformatf("t7_irq_w%0d", i), 32'(irq_low), 32'(IrqEn));
    end
    @(negedge clk);
    chk("t7_count5",   32'(count),   5);
    chk("t7_irq_drop", 32'(irq_low), 0);
    hold_busy = 1'b0;
    @(negedge clk);
    chk("t7_count4",   32'(count),   4);
    chk("t7_irq_lag",  32'(irq_low), 0);
    @(negedge clk);
    chk("t7_irq_rise", 32'(irq_low), 32'(IrqEn));
    wait_drain("t7");

    // Reset mid-burst, then confirm the queue still works.
    for (int i = 0; i < 3; i++) write_byte(8'(8'h51 + i));
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("mid");
    @(negedge clk);
    rst = 1'b0;
    write_byte(8'h7E);
    wait_drain("t8");
    chk("t8_recover", 32'(sent_q[sent_q.size() - 1]), 32'h7E);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
